// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared helpers for the synchronous FIFO family: a ceiling-log2 helper and
// functions that derive depth and pointer/count widths from ADDR_WIDTH.
// No ports.
package fifo_pkg;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
  function automatic int clog2_int(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart;
  // the occupancy count shares that width (0..DEPTH).
  function automatic int fifo_ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_PTR_WIDTH  = fifo_ptr_width(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// DEPTH x DATA_WIDTH simple dual-port storage: synchronous write, asynchronous
// read, no reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index
//   rdata  - read data (combinational from raddr)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Single-clock FIFO with configurable width/depth, almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow, synchronous flush
// and an optional first-word-fall-through read path.
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   clear         - synchronous flush, wins over push/pop
//   push, data_in - write request and data
//   pop           - read request
//   data_out      - read data (registered, or head word when FWFT=1)
//   full, empty, almost_full, almost_empty, count - occupancy status
//   overflow, underflow - sticky error flags, cleared by rst or clear
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PTR_W = fifo_ptr_width(ADDR_WIDTH);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_CNT    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT    = PTR_W'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $fatal(1, "fifo_sync_param: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $fatal(1, "fifo_sync_param: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  // Modulo subtraction handles the wrap bit; all flags decode from this.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A simultaneous pop frees the slot, so a push into a full FIFO is taken
  // when paired with a pop. The head word is read combinationally before the
  // edge overwrites that same slot.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

  if (FWFT == 0) begin : g_std_read
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (clear) begin
        dout_q <= '0;
      end else if (rd_en) begin
        dout_q <= rd_data;
      end
    end

    assign data_out = dout_q;
  end else begin : g_fwft_read
    // Head word is shown directly; forced to zero so stale memory never
    // leaks out while the FIFO is empty.
    assign data_out = empty ? '0 : rd_data;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       push;
  logic       pop;
  logic [7:0] data_in;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a plain queue plus the registered read word.
  logic [7:0] mq[$];
  logic [7:0] m_dout0;
  bit         m_ovf, m_unf;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout0 = 8'd0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_edge(input bit p_push, input bit p_pop, input bit p_clr, input logic [7:0] d);
    bit was_full, was_empty;
    if (p_clr) begin
      model_reset();
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (p_push && was_full && !p_pop) m_ovf = 1'b1;
      if (p_pop && was_empty) m_unf = 1'b1;
      if (p_pop && !was_empty) m_dout0 = mq.pop_front();
      if (p_push && (!was_full || p_pop)) mq.push_back(d);
    end
  endtask

  task automatic step(input bit p_push, input bit p_pop, input bit p_clr, input logic [7:0] d);
    push    = p_push;
    pop     = p_pop;
    clear   = p_clr;
    data_in = d;
    @(posedge clk);
    model_edge(p_push, p_pop, p_clr, d);
    @(negedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      sz = mq.size();
      chk("count0", cnt0, sz);
      chk("count1", cnt1, sz);
      chk("full0", full0, sz == DEPTH);
      chk("full1", full1, sz == DEPTH);
      chk("empty0", empty0, sz == 0);
      chk("empty1", empty1, sz == 0);
      chk("almost_full0", af0, sz >= 6);
      chk("almost_full1", af1, sz >= 6);
      chk("almost_empty0", ae0, sz <= 1);
      chk("almost_empty1", ae1, sz <= 1);
      chk("overflow0", ovf0, m_ovf);
      chk("overflow1", ovf1, m_ovf);
      chk("underflow0", unf0, m_unf);
      chk("underflow1", unf1, m_unf);
      chk("data_out0", dout0, m_dout0);
      chk("data_out1", dout1, (sz == 0) ? 32'd0 : 32'(mq[0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals[8]  = '{8'd132, 8'd45, 8'd222, 8'd177, 8'd13, 8'd189, 8'd91, 8'd33};
    logic [7:0] wvals[8] = '{8'd29, 8'd230, 8'd138, 8'd213, 8'd254, 8'd243, 8'd107, 8'd85};

    rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'd0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_empty", empty0, 1);
    chk("reset_count", cnt0, 0);
    chk("reset_ae", ae0, 1);
    rst = 1'b0;

    // 1: asynchronous reset mid-cycle
    step(1, 0, 0, 8'd132);
    step(1, 0, 0, 8'd45);
    step(1, 0, 0, 8'd222);
    chk("t1_count3", cnt0, 3);
    chk("t1_dout1_head", dout1, 132);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t1_async_empty", empty0, 1);
    chk("t1_async_count", cnt0, 0);
    chk("t1_async_dout0", dout0, 0);
    chk("t1_async_dout1", dout1, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 8'd7);
    chk("t1_push_after_rst", cnt0, 1);
    step(0, 1, 0, 8'd0);
    chk("t1_pop7", dout0, 7);

    // 2: fill to full, thresholds, overflow
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, vals[i]);
      if (i == 0) chk("t2_ae_at1", ae0, 1);
      if (i == 1) chk("t2_ae_at2", ae0, 0);
      if (i == 4) chk("t2_af_at5", af0, 0);
      if (i == 5) chk("t2_af_at6", af0, 1);
      if (i == 6) chk("t2_full_at7", full0, 0);
      if (i == 7) chk("t2_full_at8", full0, 1);
    end
    step(1, 0, 0, 8'd109);
    chk("t2_overflow", ovf0, 1);
    chk("t2_count_stays", cnt0, 8);

    // 3: drain with registered reads, then underflow
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'd0);
      chk("t3_read", dout0, vals[i]);
    end
    chk("t3_empty", empty0, 1);
    step(0, 1, 0, 8'd0);
    chk("t3_underflow", unf0, 1);
    chk("t3_dout_holds", dout0, 33);
    step(0, 0, 1, 8'd0);
    chk("t3_clear_ovf", ovf0, 0);
    chk("t3_clear_unf", unf0, 0);

    // 4: push+pop while full
    for (int i = 0; i < 8; i++) step(1, 0, 0, vals[i]);
    step(1, 1, 0, 8'd109);
    chk("t4_count", cnt0, 8);
    chk("t4_dout", dout0, 132);
    chk("t4_no_ovf", ovf0, 0);
    for (int i = 1; i < 8; i++) begin
      step(0, 1, 0, 8'd0);
      chk("t4_read", dout0, vals[i]);
    end
    step(0, 1, 0, 8'd0);
    chk("t4_read_109", dout0, 109);

    // 5: pointer wrap
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 8'(i + 1));
      step(0, 1, 0, 8'd0);
      chk("t5_pre_read", dout0, i + 1);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 0, wvals[i]);
    chk("t5_full", full0, 1);
    step(1, 0, 0, 8'd12);
    chk("t5_overflow", ovf0, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 8'd0);
      chk("t5_read", dout0, wvals[i]);
    end
    chk("t5_empty", empty0, 1);

    // 6: FWFT head visibility and clear overriding push
    step(0, 1, 0, 8'd0);
    chk("t6_underflow", unf1, 1);
    step(1, 0, 0, 8'd29);
    chk("t6_fwft_empty", empty1, 0);
    chk("t6_fwft_dout", dout1, 29);
    chk("t6_std_holds", dout0, 85);
    step(1, 0, 1, 8'd55);
    chk("t6_clr_count", cnt1, 0);
    chk("t6_clr_empty", empty1, 1);
    chk("t6_clr_dout1", dout1, 0);
    chk("t6_clr_dout0", dout0, 0);
    chk("t6_clr_ovf", ovf1, 0);
    chk("t6_clr_unf", unf1, 0);
    step(0, 0, 0, 8'd0);
    chk("t6_still_empty", cnt0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
